rsa_job_sequencer: RTL
======================

# rsa_job_sequencer

Synthesizable initiator for the RSA `control` block. It accepts one job (p, q, mode, message) over a valid/ready request port and drives `control`'s two-phase protocol: pulse `reset_inverter`, wait for `inverter_finish`, pulse `reset_mod_exp`, wait for `mod_exp_finish`. It then returns `msg_out` over a valid/ready response port. It sits between a host/bus front end and one `control` instance, and replaces bench-style driving in silicon.

## Interface
Parameters
- WIDTH, 128, prime width; message width is 2*WIDTH
- TIMEOUT, 0, max cycles per phase (BLANK+WAIT) before abort; 0 disables timeout
- TIMEOUT_W, 32, timeout counter width

Ports
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  job offered
- req_ready  out  1  sequencer idle, can accept
- req_p, req_q  in  WIDTH  primes
- req_encrypt_decrypt  in  1  mode passed to control
- req_msg  in  2*WIDTH  input message
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_msg  out  2*WIDTH  control result
- rsp_timeout  out  1  job aborted by timeout
- rsp_mismatch  out  1  round-trip check failed (see Configuration)
- busy  out  1  state != IDLE
- p, q  out  WIDTH  to control
- encrypt_decrypt  out  1  to control
- msg_in  out  2*WIDTH  to control
- reset_inverter, reset_mod_exp  out  1  one-cycle start pulses to control
- inverter_finish, mod_exp_finish  in  1  from control
- msg_out  in  2*WIDTH  from control

## Operation
- States: IDLE, INV_GO, INV_BLANK, INV_WAIT, EXP_GO, EXP_BLANK, EXP_WAIT, DONE. The round-trip states RT_INV_GO … RT_EXP_WAIT exist only when the macro is defined.
- req_ready = (state==IDLE). Accept on req_valid&&req_ready: register p, q, encrypt_decrypt, msg_in from the req_* inputs, then go to INV_GO. These outputs stay stable until the FSM returns to IDLE.
- INV_GO: reset_inverter=1 for exactly this cycle; timeout counter cleared. Next state is INV_BLANK.
- BLANK states: last exactly one cycle. The finish input is ignored here, so a finish level left over from the previous job is not mistaken for completion.
- INV_WAIT: when inverter_finish=1, go to EXP_GO. EXP_GO/EXP_BLANK/EXP_WAIT behave the same way, using reset_mod_exp and mod_exp_finish.
- Leaving EXP_WAIT: capture msg_out into rsp_msg, then go to DONE.
- DONE: rsp_valid=1. rsp_msg, rsp_timeout and rsp_mismatch are held until rsp_ready=1. On rsp_valid&&rsp_ready, go to IDLE. There is no same-cycle re-accept.
- Timeout (TIMEOUT>0): the counter increments in BLANK and WAIT states and saturates. If it reaches TIMEOUT with no finish, go to DONE with rsp_timeout=1 and rsp_msg=0.
- Reset values: all outputs 0 except req_ready=1. Registered operands and rsp_msg are cleared to 0.
- Reset mid-job: on the next edge the state is IDLE and all pulses are 0. The pending job is dropped with no response and no further control pulses.

## Timing
- Accept edge = cycle 0. Pulses and responses with both finish inputs already high:
  - reset_inverter high in cycle 1
  - reset_mod_exp high in cycle 4
  - rsp_valid high in cycle 7
- Each extra cycle of finish latency adds one cycle of latency.
- All outputs are registered or decoded from state only. No combinational path exists from the finish inputs or rsp_ready to the outputs.
- Pulses are never wider than one cycle and never overlap.

## Configuration
- RSA_SEQ_ROUNDTRIP_EN defined:
  - After the forward EXP_WAIT, latch the forward result into rsp_msg.
  - Set encrypt_decrypt to the inverse of the latched mode and msg_in to the forward result; p and q are unchanged.
  - Rerun both phases, with the same blanking and timeout rules.
  - In DONE, rsp_mismatch = (msg_out of the second pass != original req_msg).
  - Latency doubles: minimum rsp_valid is cycle 13.
  - A timeout in either pass sets rsp_timeout=1, rsp_msg=0 and rsp_mismatch=0.
- Not defined: round-trip states are absent, rsp_mismatch is tied to 0, and minimum latency is 7 cycles.

## Test plan
- Reset held 3 cycles, then released -> every output is 0, req_ready=1, busy=0.
- Stub control with finish inputs held at 1, request p=113680897410347, q=7999808077935876437321, msg=0x7b0000000000, mode 0 -> reset_inverter only in cycle 1, reset_mod_exp only in cycle 4, rsp_valid in cycle 7, rsp_msg equal to the stub's msg_out.
- Real control, p=8475698667747010771, q=11297384090418420749, msg=0x9d, mode 0, with RSA_SEQ_ROUNDTRIP_EN -> rsp_mismatch=0, rsp_timeout=0. The same job with a stub that corrupts the second-pass msg_out -> rsp_mismatch=1.
- TIMEOUT=100, stub that never raises mod_exp_finish -> rsp_valid with rsp_timeout=1 and rsp_msg=0, no second reset_mod_exp pulse.
- rsp_ready held low 20 cycles in DONE while req_valid=1 with new data -> rsp_* stable, req_ready=0, new job not accepted until the handshake completes, then accepted one cycle later.
- reset pulsed during INV_WAIT -> IDLE on the next edge, reset_mod_exp never asserted, no rsp_valid.

Source files
------------

// File: rtl/rsa_job_sequencer.sv
// Job initiator for the RSA control block: accepts one job, runs the inverter and
// mod-exp phases, returns the result. Optional round-trip self-check: RSA_SEQ_ROUNDTRIP_EN.
module rsa_job_sequencer #(
  parameter int WIDTH     = 128,
  parameter int TIMEOUT   = 0,
  parameter int TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_p,
  input  logic [WIDTH-1:0]     req_q,
  input  logic                 req_encrypt_decrypt,
  input  logic [2*WIDTH-1:0]   req_msg,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_msg,
  output logic                 rsp_timeout,
  output logic                 rsp_mismatch,
  output logic                 busy,
  output logic [WIDTH-1:0]     p,
  output logic [WIDTH-1:0]     q,
  output logic                 encrypt_decrypt,
  output logic [2*WIDTH-1:0]   msg_in,
  output logic                 reset_inverter,
  output logic                 reset_mod_exp,
  input  logic                 inverter_finish,
  input  logic                 mod_exp_finish,
  input  logic [2*WIDTH-1:0]   msg_out
);

  typedef enum logic [3:0] {
    IDLE, INV_GO, INV_BLANK, INV_WAIT, EXP_GO, EXP_BLANK, EXP_WAIT, DONE
`ifdef RSA_SEQ_ROUNDTRIP_EN
    , RT_INV_GO, RT_INV_BLANK, RT_INV_WAIT, RT_EXP_GO, RT_EXP_BLANK, RT_EXP_WAIT
`endif
  } state_t;

  localparam bit                 TO_EN   = (TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     p_q, p_d, q_q, q_d;
  logic                 mode_q, mode_d;
  logic [2*WIDTH-1:0]   msg_in_q, msg_in_d;
  logic [2*WIDTH-1:0]   rsp_msg_q, rsp_msg_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 to_hit;

  // The counter has already covered every earlier cycle of this phase, so this
  // cycle is the TIMEOUT-th one.
  assign to_hit = TO_EN && (cnt_q >= TO_LAST);

`ifdef RSA_SEQ_ROUNDTRIP_EN
  logic [2*WIDTH-1:0] orig_q, orig_d;
  logic               mismatch_q, mismatch_d;
  assign rsp_mismatch = mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    p_d           = p_q;
    q_d           = q_q;
    mode_d        = mode_q;
    msg_in_d      = msg_in_q;
    rsp_msg_d     = rsp_msg_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = (cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
`ifdef RSA_SEQ_ROUNDTRIP_EN
    orig_d        = orig_q;
    mismatch_d    = mismatch_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        p_d           = req_p;
        q_d           = req_q;
        mode_d        = req_encrypt_decrypt;
        msg_in_d      = req_msg;
        rsp_timeout_d = 1'b0;
`ifdef RSA_SEQ_ROUNDTRIP_EN
        orig_d        = req_msg;
        mismatch_d    = 1'b0;
`endif
        state_d       = INV_GO;
      end
      INV_GO:    begin cnt_d = '0; state_d = INV_BLANK; end
      INV_BLANK: state_d = INV_WAIT;
      EXP_GO:    begin cnt_d = '0; state_d = EXP_BLANK; end
      EXP_BLANK: state_d = EXP_WAIT;
      INV_WAIT:  if (inverter_finish) state_d = EXP_GO;
                 else if (to_hit) begin
                   state_d = DONE; rsp_timeout_d = 1'b1; rsp_msg_d = '0;
                 end
      EXP_WAIT:  if (mod_exp_finish) begin
                   rsp_msg_d = msg_out;
`ifdef RSA_SEQ_ROUNDTRIP_EN
                   mode_d    = ~mode_q;
                   msg_in_d  = msg_out;
                   state_d   = RT_INV_GO;
`else
                   state_d   = DONE;
`endif
                 end else if (to_hit) begin
                   state_d = DONE; rsp_timeout_d = 1'b1; rsp_msg_d = '0;
                 end
`ifdef RSA_SEQ_ROUNDTRIP_EN
      RT_INV_GO:    begin cnt_d = '0; state_d = RT_INV_BLANK; end
      RT_INV_BLANK: state_d = RT_INV_WAIT;
      RT_EXP_GO:    begin cnt_d = '0; state_d = RT_EXP_BLANK; end
      RT_EXP_BLANK: state_d = RT_EXP_WAIT;
      RT_INV_WAIT:  if (inverter_finish) state_d = RT_EXP_GO;
                    else if (to_hit) begin
                      state_d = DONE; rsp_timeout_d = 1'b1; rsp_msg_d = '0;
                    end
      RT_EXP_WAIT:  if (mod_exp_finish) begin
                      mismatch_d = (msg_out != orig_q);
                      state_d    = DONE;
                    end else if (to_hit) begin
                      state_d = DONE; rsp_timeout_d = 1'b1; rsp_msg_d = '0;
                    end
`endif
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      p_q           <= '0;
      q_q           <= '0;
      mode_q        <= 1'b0;
      msg_in_q      <= '0;
      rsp_msg_q     <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
`ifdef RSA_SEQ_ROUNDTRIP_EN
      orig_q        <= '0;
      mismatch_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      q_q           <= q_d;
      mode_q        <= mode_d;
      msg_in_q      <= msg_in_d;
      rsp_msg_q     <= rsp_msg_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
`ifdef RSA_SEQ_ROUNDTRIP_EN
      orig_q        <= orig_d;
      mismatch_q    <= mismatch_d;
`endif
    end
  end

  // Every output is a register or a decode of state, so no finish/ready input reaches an output.
  assign req_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign rsp_valid       = (state_q == DONE);
  assign rsp_msg         = rsp_msg_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign p               = p_q;
  assign q               = q_q;
  assign encrypt_decrypt = mode_q;
  assign msg_in          = msg_in_q;
`ifdef RSA_SEQ_ROUNDTRIP_EN
  assign reset_inverter  = (state_q == INV_GO) || (state_q == RT_INV_GO);
  assign reset_mod_exp   = (state_q == EXP_GO) || (state_q == RT_EXP_GO);
`else
  assign reset_inverter  = (state_q == INV_GO);
  assign reset_mod_exp   = (state_q == EXP_GO);
`endif

endmodule
